// File: rtl/mips_div_seq_pkg.sv
// ============================================================================
// mips_div_seq_pkg : shared constants for the sequential MIPS divider
// Rev 1.0
// ============================================================================
`default_nettype none

package mips_div_seq_pkg;

    localparam int DIV_WIDTH    = 32;
    localparam int DIV_LATENCY  = 34;
    localparam int DIV0_LATENCY = 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

endpackage

`default_nettype wire

// File: rtl/mips_div_seq_div_step.sv
// ============================================================================
// div_step : one combinational restoring-division iteration
// Rev 1.0
// ============================================================================
`default_nettype none

module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_r,
    input  logic             i_q_msb,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_r,
    output logic             o_q_bit
);

    logic [WIDTH:0] w_t;
    logic [WIDTH:0] w_diff;

    assign w_t = {i_r, i_q_msb};

    // Subtract as add of the inverted, zero-extended divisor with carry-in 1
    assign w_diff  = w_t + {1'b1, ~i_d} + (WIDTH+1)'(1);
    assign o_q_bit = ~w_diff[WIDTH];
    assign o_r     = o_q_bit ? w_diff[WIDTH-1:0] : w_t[WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/mips_div_seq.sv
// ============================================================================
// mips_div_seq : multi-cycle radix-2 restoring divider for MIPS DIV/DIVU
// Rev 1.0
// ============================================================================
`default_nettype none

module mips_div_seq
    import mips_div_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    // Partial remainder stays below the divisor, so its extra top bit is always zero
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [CNT_W-1:0] r_cnt;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dz;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_dbz;
    logic             r_done;

    logic             w_busy;
    logic             w_go;
    logic             w_div0;
    logic [WIDTH-1:0] w_dvd_abs;
    logic [WIDTH-1:0] w_dvs_abs;
    logic [WIDTH-1:0] w_step_r;
    logic             w_qbit;

    assign w_go      = start & ~cancel;
    assign w_div0    = (divisor == '0);
    assign w_dvd_abs = (sign & dividend[WIDTH-1]) ? ('0 - dividend) : dividend;
    assign w_dvs_abs = (sign & divisor[WIDTH-1])  ? ('0 - divisor)  : divisor;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_r     (r_r),
        .i_q_msb (r_q[WIDTH-1]),
        .i_d     (r_d),
        .o_r     (w_step_r),
        .o_q_bit (w_qbit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_go) w_next = w_div0 ? S_FIX : S_CALC;
            S_CALC: begin
                if (cancel)                            w_next = S_IDLE;
                else if (r_cnt == CNT_W'(WIDTH - 1))   w_next = S_FIX;
            end
            S_FIX:  w_next = cancel ? S_IDLE : S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_r     <= '0;
            r_q     <= '0;
            r_d     <= '0;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_dbz   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            // done lags the DONE state by one edge; a cancel there suppresses it
            r_done <= (r_state == S_DONE) & ~cancel;
            case (r_state)
                S_IDLE: if (w_go) begin
                    r_r     <= '0;
                    r_cnt   <= '0;
                    r_d     <= w_dvs_abs;
                    r_dz    <= w_div0;
                    r_q     <= w_div0 ? dividend : w_dvd_abs;
                    r_neg_q <= sign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    r_neg_r <= sign & dividend[WIDTH-1];
                end
                S_CALC: begin
                    r_r   <= w_step_r;
                    r_q   <= {r_q[WIDTH-2:0], w_qbit};
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                S_FIX: if (!cancel) begin
                    r_dbz <= r_dz;
                    if (r_dz) begin
                        r_quot <= '1;
                        r_rem  <= r_q;
                    end else begin
                        r_quot <= r_neg_q ? ('0 - r_q) : r_q;
                        r_rem  <= r_neg_r ? ('0 - r_r) : r_r;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = w_busy;
    assign done        = r_done;
    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_mips_div_seq.sv
// ============================================================================
// tb_mips_div_seq : directed self-checking bench for mips_div_seq
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mips_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sign;
    logic        cancel;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int errors = 0;
    int checks = 0;

    mips_div_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .sign        (sign),
        .dividend    (dividend),
        .divisor     (divisor),
        .cancel      (cancel),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; sign = s; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0; sign = 1'b0; dividend = '0; divisor = '0;
    endtask

    // Counts negedges after the sampling edge until done; optionally pulses a stray start
    task automatic wait_done(input int stray_k, output int lat, output int busy_low);
        lat = 0;
        busy_low = 0;
        while (!done && lat < 100) begin
            if (!busy) busy_low++;
            if (lat == stray_k) begin
                start = 1'b1; sign = 1'b1; dividend = 32'd5; divisor = 32'd1;
            end else begin
                start = 1'b0; sign = 1'b0; dividend = '0; divisor = '0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
    endtask

    task automatic run(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er, input logic edz,
                       input int elat, input int stray_k);
        int lat;
        int bl;
        launch(s, a, b);
        wait_done(stray_k, lat, bl);
        check({tag, " quotient"}, quotient, eq);
        check({tag, " remainder"}, remainder, er);
        check({tag, " div_by_zero"}, {31'b0, div_by_zero}, {31'b0, edz});
        check({tag, " latency"}, 32'(lat), 32'(elat));
        check({tag, " busy_gaps"}, 32'(bl), 32'd0);
        @(negedge clk);
        check({tag, " done_pulse_width"}, {31'b0, done}, 32'd0);
        check({tag, " busy_after"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        rst = 1'b1; start = 1'b0; sign = 1'b0; cancel = 1'b0;
        dividend = '0; divisor = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset quotient", quotient, 32'd0);
        check("reset remainder", remainder, 32'd0);
        check("reset div_by_zero", {31'b0, div_by_zero}, 32'd0);
        rst = 1'b0;

        run("u100_7",   1'b0, 32'd100,        32'd7,        32'd14,       32'd2,        1'b0, 34, -1);
        run("s-7_2",    1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 34, -1);
        run("s7_-2",    1'b1, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0, 34, -1);
        run("s_ovf",    1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 34, -1);
        run("u_max_1",  1'b0, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF, 32'd0,        1'b0, 34, -1);
        run("u_fff9_2", 1'b0, 32'hFFFFFFF9,   32'd2,        32'h7FFFFFFC, 32'd1,        1'b0, 34, -1);
        run("div0",     1'b0, 32'h12345678,   32'd0,        32'hFFFFFFFF, 32'h12345678, 1'b1, 2,  -1);
        run("s-100_7",  1'b1, 32'hFFFFFF9C,   32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 34, -1);
        run("stray",    1'b0, 32'd1000,       32'd3,        32'd333,      32'd1,        1'b0, 34, 10);

        // Cancel during CALC
        launch(1'b0, 32'd50, 32'd5);
        repeat (20) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel busy", {31'b0, busy}, 32'd0);
        seen = 0;
        repeat (40) begin
            if (done) seen++;
            @(negedge clk);
        end
        check("cancel no_done", 32'(seen), 32'd0);
        check("cancel quotient_kept", quotient, 32'd333);
        check("cancel remainder_kept", remainder, 32'd1);

        run("fresh",    1'b0, 32'd50,         32'd5,        32'd10,       32'd0,        1'b0, 34, -1);

        // Asynchronous reset mid-operation
        launch(1'b0, 32'd1000, 32'd3);
        repeat (15) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("areset busy", {31'b0, busy}, 32'd0);
        check("areset done", {31'b0, done}, 32'd0);
        check("areset quotient", quotient, 32'd0);
        check("areset remainder", remainder, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            if (done) seen++;
            @(negedge clk);
        end
        check("areset no_done", 32'(seen), 32'd0);
        check("areset idle", {31'b0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
